text_write_arbiter: RTL and testbench

- Shares the single TextGraphic text-RAM write port (WAddr/WData/Write) between NREQ independent writers (e.g. console writer, status overlay, debug dumper).
- Fair round-robin arbitration, at most one cell write per clock.
- Built-in fill engine clears or paints the whole screen with one cell word; it has exclusive ownership of the port while running.
- Sits between the writer blocks and TextGraphic inside XrcCore, clocked from the BUFG'd 50 MHz clock.

---
 rtl/text_write_arbiter_if.sv | 26 ++
 rtl/text_write_arbiter.sv | 173 +++++++++++++++++
 tb/tb_text_write_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/text_write_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : text_write_arbiter_if                                           |
// | Purpose  : Requester-side bundle for the text-RAM write arbiter. Carries   |
// |            NREQ packed valid/addr/data lanes and the one-hot ready return. |
// | Signals  : req_valid [NREQ]     requester i has a write pending            |
// |            req_addr  [NREQ*AW]  lane i at bits [i*AW +: AW]                |
// |            req_data  [NREQ*DW]  lane i at bits [i*DW +: DW]                |
// |            req_ready [NREQ]     one-hot (or zero) acceptance               |
// | Modports : master (writers), slave (arbiter)                               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface text_write_arbiter_if #(
   parameter int NREQ = 3,
   parameter int AW   = 13,
   parameter int DW   = 18
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;

   modport master (output req_valid, output req_addr, output req_data, input req_ready);
   modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface
`default_nettype wire

// File: rtl/text_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : text_write_arbiter                                              |
// | Purpose  : Shares the TextGraphic text-RAM write port between NREQ writers |
// |            with round-robin arbitration (one cell write per clock), plus a |
// |            fill engine that paints all CELLS cells with one word while     |
// |            holding exclusive ownership of the port.                        |
// | Ports    : clk50       system clock, rising edge                           |
// |            rst_n       asynchronous active-low reset                       |
// |            req_if      requester bundle (slave side)                       |
// |            fill_start  one-cycle pulse that starts a screen fill           |
// |            fill_data   cell word for the fill, sampled with fill_start     |
// |            fill_busy   fill engine owns the port                           |
// |            fill_done   one-cycle pulse at fill completion                  |
// |            oob_drop    one-cycle pulse: out-of-range request discarded     |
// |            WAddr/WData/Write  registered TextGraphic write port            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module text_write_arbiter #(
   parameter int NREQ  = 3,
   parameter int AW    = 13,
   parameter int DW    = 18,
   parameter int CELLS = 7320
) (
   input  wire logic              clk50,
   input  wire logic              rst_n,
   text_write_arbiter_if.slave    req_if,
   input  wire logic              fill_start,
   input  wire logic [DW-1:0]     fill_data,
   output logic                   fill_busy,
   output logic                   fill_done,
   output logic                   oob_drop,
   output logic [AW-1:0]          WAddr,
   output logic [DW-1:0]          WData,
   output logic                   Write
);

   localparam int PW = $clog2(NREQ);

   localparam logic [AW-1:0] C_CELLS     = AW'(CELLS);
   localparam logic [AW-1:0] C_LAST_CELL = AW'(CELLS - 1);
   localparam logic [PW-1:0] C_LAST_REQ  = PW'(NREQ - 1);

   // ST_FEND is a one-cycle tail after the last fill write so that Write,
   // fill_busy and the fill_done pulse all change on the same edge.
   localparam logic [1:0] ST_ARB  = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_FEND = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] fword_q, fword_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          write_q, write_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          oob_q, oob_d;

   logic [NREQ-1:0] grant_vec;
   logic [PW-1:0]   grant_idx;
   logic            grant_any;
   logic [PW-1:0]   cand;
   logic            accept;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;

   // Round-robin search starting at the pointer, wrapping modulo NREQ.
   always_comb begin
      grant_vec = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = PW'((int'(ptr_q) + k) % NREQ);
         if (!grant_any && req_if.req_valid[cand]) begin
            grant_any       = 1'b1;
            grant_idx       = cand;
            grant_vec[cand] = 1'b1;
         end
      end
   end

   // A pending fill_start takes the port this cycle, so nobody is accepted.
   assign accept           = (state_q == ST_ARB) && !fill_start && grant_any;
   assign req_if.req_ready = accept ? grant_vec : '0;
   assign sel_addr         = req_if.req_addr[int'(grant_idx)*AW +: AW];
   assign sel_data         = req_if.req_data[int'(grant_idx)*DW +: DW];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      fword_d = fword_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      write_d = 1'b0;
      done_d  = 1'b0;
      oob_d   = 1'b0;
      case (state_q)
         ST_ARB: begin
            if (fill_start) begin
               state_d = ST_FILL;
               fword_d = fill_data;
               cnt_d   = '0;
            end else if (accept) begin
               ptr_d = (grant_idx == C_LAST_REQ) ? '0 : grant_idx + PW'(1);
               // Out-of-range requests are consumed but never reach the RAM.
               if (sel_addr < C_CELLS) begin
                  waddr_d = sel_addr;
                  wdata_d = sel_data;
                  write_d = 1'b1;
               end else begin
                  oob_d = 1'b1;
               end
            end
         end
         ST_FILL: begin
            waddr_d = cnt_q;
            wdata_d = fword_q;
            write_d = 1'b1;
            if (cnt_q == C_LAST_CELL) begin
               state_d = ST_FEND;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         ST_FEND: begin
            state_d = ST_ARB;
            done_d  = 1'b1;
         end
         default: state_d = ST_ARB;
      endcase
      busy_d = (state_d != ST_ARB);
   end

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ARB;
         ptr_q   <= '0;
         cnt_q   <= '0;
         fword_q <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         oob_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         fword_q <= fword_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         oob_q   <= oob_d;
      end
   end

   assign WAddr     = waddr_q;
   assign WData     = wdata_q;
   assign Write     = write_q;
   assign fill_busy = busy_q;
   assign fill_done = done_q;
   assign oob_drop  = oob_q;

endmodule
`default_nettype wire

// File: tb/tb_text_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_text_write_arbiter                                           |
// | Purpose  : Self-checking bench for text_write_arbiter. A reference model   |
// |            predicts ready and the write pushed to a scoreboard each cycle; |
// |            the scoreboard is popped when the registered write appears.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_text_write_arbiter;
   localparam int NREQ  = 3;
   localparam int AW    = 13;
   localparam int DW    = 18;
   localparam int CELLS = 7320;

   logic          clk50 = 1'b0;
   logic          rst_n;
   logic          fill_start;
   logic [DW-1:0] fill_data;
   logic          fill_busy, fill_done, oob_drop, Write;
   logic [AW-1:0] WAddr;
   logic [DW-1:0] WData;

   text_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

   text_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CELLS(CELLS)) dut (
      .clk50      (clk50),
      .rst_n      (rst_n),
      .req_if     (bus.slave),
      .fill_start (fill_start),
      .fill_data  (fill_data),
      .fill_busy  (fill_busy),
      .fill_done  (fill_done),
      .oob_drop   (oob_drop),
      .WAddr      (WAddr),
      .WData      (WData),
      .Write      (Write)
   );

   always #10 clk50 = ~clk50;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   logic [AW+DW-1:0] sb[$];
   int            m_state;   // 0 arbitrate, 1 fill, 2 fill tail
   int            m_ptr;
   int            m_cnt;
   logic [DW-1:0] m_word;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;
   bit            e_wr, e_oob, e_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_state = 0; m_ptr = 0; m_cnt = 0; m_word = '0;
      m_waddr = '0; m_wdata = '0;
      e_wr = 1'b0; e_oob = 1'b0; e_done = 1'b0;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req_addr[i*AW +: AW] = a;
      bus.req_data[i*DW +: DW] = d;
   endtask

   // One clock: check last edge's outputs, predict this cycle, advance.
   task automatic tick();
      logic [NREQ-1:0]  er;
      logic [AW+DW-1:0] ent;
      logic [AW-1:0]    a;
      int               g;
      int               ns;
      bit               nwr, noob, ndone;
      @(negedge clk50);
      chk("Write", 32'(Write), 32'(e_wr));
      if (e_wr) begin
         if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
         end else begin
            ent     = sb.pop_front();
            m_waddr = ent[AW+DW-1:DW];
            m_wdata = ent[DW-1:0];
         end
      end
      chk("WAddr", 32'(WAddr), 32'(m_waddr));
      chk("WData", 32'(WData), 32'(m_wdata));
      chk("oob_drop", 32'(oob_drop), 32'(e_oob));
      chk("fill_busy", 32'(fill_busy), 32'(m_state != 0));
      chk("fill_done", 32'(fill_done), 32'(e_done));
      er = '0; nwr = 1'b0; noob = 1'b0; ndone = 1'b0; ns = m_state; g = -1;
      case (m_state)
         0: begin
            if (fill_start) begin
               ns = 1; m_word = fill_data; m_cnt = 0;
            end else begin
               for (int k = 0; k < NREQ; k++) begin
                  int i;
                  i = (m_ptr + k) % NREQ;
                  if (g < 0 && bus.req_valid[i]) g = i;
               end
               if (g >= 0) begin
                  er[g] = 1'b1;
                  m_ptr = (g + 1) % NREQ;
                  a = bus.req_addr[g*AW +: AW];
                  if (int'(a) < CELLS) begin
                     sb.push_back({a, bus.req_data[g*DW +: DW]});
                     nwr = 1'b1;
                  end else begin
                     noob = 1'b1;
                  end
               end
            end
         end
         1: begin
            sb.push_back({AW'(m_cnt), m_word});
            nwr = 1'b1;
            if (m_cnt == CELLS - 1) ns = 2;
            else m_cnt++;
         end
         default: begin
            ns = 0; ndone = 1'b1;
         end
      endcase
      chk("req_ready", 32'(bus.req_ready), 32'(er));
      m_state = ns; e_wr = nwr; e_oob = noob; e_done = ndone;
      @(posedge clk50);
      #1;
   endtask

   initial begin
      rst_n          = 1'b0;
      fill_start     = 1'b0;
      fill_data      = '0;
      bus.req_valid  = '0;
      bus.req_addr   = '0;
      bus.req_data   = '0;
      model_reset();

      // Reset state
      tick(); tick();
      rst_n = 1'b1;

      // Single write from requester 1
      set_req(1, 13'h0005, 18'h0F041);
      bus.req_valid = 3'b010; tick();
      bus.req_valid = 3'b000; tick(); tick();

      // Move pointer to 0 via one grant to requester 2
      set_req(2, 13'd100, 18'h12345);
      bus.req_valid = 3'b100; tick();
      bus.req_valid = 3'b000; tick();

      // All three valid: 0,1,2,0,1,2
      set_req(0, 13'd10, 18'h00A0A);
      set_req(1, 13'd11, 18'h00B0B);
      set_req(2, 13'd12, 18'h00C0C);
      bus.req_valid = 3'b111; repeat (6) tick();
      bus.req_valid = 3'b000; tick();

      // Pointer to 1, then only 0 and 2 valid: 2,0,2,0
      bus.req_valid = 3'b001; tick();
      bus.req_valid = 3'b000; tick();
      bus.req_valid = 3'b101; repeat (4) tick();
      bus.req_valid = 3'b000; tick();

      // Out-of-range requests
      set_req(0, 13'd7320, 18'h2AAAA);
      bus.req_valid = 3'b001; tick();
      set_req(0, 13'd8191, 18'h15555); tick();
      bus.req_valid = 3'b000; tick(); tick();

      // Fill started together with requester 0 valid
      set_req(0, 13'd20, 18'h01234);
      bus.req_valid = 3'b001;
      fill_start = 1'b1; fill_data = 18'h00F20; tick();
      fill_start = 1'b0; fill_data = 18'h3FFFF;
      for (int n = 0; n < CELLS + 1; n++) begin
         fill_start = (n == 50);
         tick();
      end
      fill_start = 1'b0;
      tick();                       // requester 0 served right after the fill
      bus.req_valid = 3'b000; tick(); tick();

      // Asynchronous reset after the 100th fill write
      fill_start = 1'b1; fill_data = 18'h2A5C3; tick();
      fill_start = 1'b0;
      repeat (100) tick();
      chk("fill_w100_addr", 32'(WAddr), 32'd99);
      chk("fill_w100_data", 32'(WData), 32'h2A5C3);
      #2 rst_n = 1'b0;
      #1;
      chk("areset_Write", 32'(Write), 32'd0);
      chk("areset_WAddr", 32'(WAddr), 32'd0);
      chk("areset_WData", 32'(WData), 32'd0);
      chk("areset_busy", 32'(fill_busy), 32'd0);
      chk("areset_done", 32'(fill_done), 32'd0);
      chk("areset_oob", 32'(oob_drop), 32'd0);
      model_reset();
      tick();
      rst_n = 1'b1;
      tick();

      // New fill after reset starts at address 0
      fill_start = 1'b1; fill_data = 18'h15A5A; tick();
      fill_start = 1'b0;
      repeat (CELLS + 1) tick();
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
